// File: rtl/dsp_mac_sequencer_if.sv
// dsp_mac_sequencer_if: operand stream, result stream and DSP slice control bundle.
// Ports: in_* operand handshake, res_* result handshake, dsp_* slice control and P return.
interface dsp_mac_sequencer_if #(
    parameter int RES_W = 48
);
    logic             in_valid;
    logic             in_ready;
    logic [17:0]      in_a;
    logic [17:0]      in_b;
    logic             in_last;
    logic             res_valid;
    logic             res_ready;
    logic [RES_W-1:0] res_data;
    logic [17:0]      dsp_a;
    logic [17:0]      dsp_b;
    logic [7:0]       dsp_opmode;
    logic             dsp_cea;
    logic             dsp_ceb;
    logic             dsp_cem;
    logic             dsp_cep;
    logic             dsp_ceopmode;
    logic             dsp_rst;
    logic [47:0]      dsp_p;

    // Sequencer side: accepts operands, returns results, drives the slice.
    modport master (
        input  in_valid, in_a, in_b, in_last, res_ready, dsp_p,
        output in_ready, res_valid, res_data,
        output dsp_a, dsp_b, dsp_opmode,
        output dsp_cea, dsp_ceb, dsp_cem, dsp_cep, dsp_ceopmode, dsp_rst
    );

    // Environment side: operand source, result sink and slice.
    modport slave (
        output in_valid, in_a, in_b, in_last, res_ready, dsp_p,
        input  in_ready, res_valid, res_data,
        input  dsp_a, dsp_b, dsp_opmode,
        input  dsp_cea, dsp_ceb, dsp_cem, dsp_cep, dsp_ceopmode, dsp_rst
    );
endinterface

// File: rtl/dsp_mac_sequencer.sv
// dsp_mac_sequencer: drives a DSP48A1-style slice as a MAC, returns dot products.
// Ports: CLK, RST (sync, active-high); bus (master): in_* pairs, res_* results,
// dsp_* slice operands/opmode/enables/reset and dsp_p feedback.
// Option: MAC_SAT_EN saturates res_data when dsp_p exceeds RES_W bits.
module dsp_mac_sequencer #(
    parameter int RES_W = 48
) (
    input logic                 CLK,
    input logic                 RST,
    dsp_mac_sequencer_if.master bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_ACC,
        S_DRAIN,
        S_HOLD
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [1:0]       r_cnt;
    logic             r_acc_d1;
    logic             r_acc_d2;
    logic [7:0]       r_opmode;
    logic             r_res_valid;
    logic [RES_W-1:0] r_res_data;

    logic             w_out_free;
    logic             w_in_ready;
    logic             w_acc;
    logic             w_first;
    logic             w_cap;
    logic [RES_W-1:0] w_res_next;

    assign w_out_free = !r_res_valid || bus.res_ready;

    always_comb begin
        w_in_ready = 1'b0;
        unique case (r_state)
            S_IDLE:  w_in_ready = w_out_free;
            S_ACC:   w_in_ready = 1'b1;
            S_DRAIN: w_in_ready = 1'b0;
            S_HOLD:  w_in_ready = bus.res_ready;
            default: w_in_ready = 1'b0;
        endcase
        if (RST) begin
            w_in_ready = 1'b0;
        end
    end

    assign w_acc = bus.in_valid && w_in_ready;
    // A tap taken while no job is open starts a new accumulation.
    assign w_first = (r_state == S_IDLE) || (r_state == S_HOLD);

    always_comb begin
        w_next = r_state;
        w_cap  = 1'b0;
        unique case (r_state)
            S_IDLE, S_HOLD: begin
                if (w_acc) begin
                    w_next = bus.in_last ? S_DRAIN : S_ACC;
                end else if (r_state == S_HOLD && bus.res_ready) begin
                    w_next = S_IDLE;
                end
            end
            S_ACC: begin
                if (w_acc && bus.in_last) begin
                    w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Last tap reaches P after A1/B1, M and P stages.
                if (r_cnt == 2'd2) begin
                    w_cap  = 1'b1;
                    w_next = S_HOLD;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

`ifdef MAC_SAT_EN
    logic [47:0] w_hi;
    assign w_hi       = bus.dsp_p >> RES_W;
    assign w_res_next = (|w_hi) ? '1 : bus.dsp_p[RES_W-1:0];
`else
    logic w_unused_p;
    assign w_unused_p = ^bus.dsp_p;
    assign w_res_next = bus.dsp_p[RES_W-1:0];
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= S_IDLE;
            r_cnt       <= 2'd0;
            r_acc_d1    <= 1'b0;
            r_acc_d2    <= 1'b0;
            r_opmode    <= 8'h00;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
        end else begin
            r_state  <= w_next;
            r_cnt    <= (r_state == S_DRAIN) ? r_cnt + 2'd1 : 2'd0;
            r_acc_d1 <= w_acc;
            r_acc_d2 <= r_acc_d1;
            // Z=0 on a job's first tap clears the previous sum;
            // otherwise Z=P, and cep gating keeps bubbles harmless.
            r_opmode <= (w_acc && w_first) ? 8'h01 : 8'h09;
            if (w_cap) begin
                r_res_valid <= 1'b1;
                r_res_data  <= w_res_next;
            end else if (bus.res_ready) begin
                r_res_valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready     = w_in_ready;
    assign bus.res_valid    = r_res_valid;
    assign bus.res_data     = r_res_data;
    assign bus.dsp_a        = w_acc ? bus.in_a : 18'd0;
    assign bus.dsp_b        = w_acc ? bus.in_b : 18'd0;
    assign bus.dsp_cea      = w_acc;
    assign bus.dsp_ceb      = w_acc;
    assign bus.dsp_cem      = 1'b1;
    assign bus.dsp_ceopmode = 1'b1;
    assign bus.dsp_cep      = r_acc_d2;
    assign bus.dsp_opmode   = r_opmode;
    assign bus.dsp_rst      = RST;
endmodule
